mul_hilo_ctrl: RTL and testbench

//  Multiply issue/writeback stage for the MIPS EX unit. Accepts MULT/MULTU/MTHI/MTLO

---
 rtl/mul_hilo_ctrl_pkg.sv | 19 +
 rtl/mul_ufix.sv | 16 +
 rtl/mul_hilo_ctrl.sv | 141 ++++++++++++++
 tb/tb_mul_hilo_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared definitions for the multiply issue/writeback stage: MDU opcodes and FSM state encodings.
package mul_hilo_ctrl_pkg;

  localparam logic [1:0] MDU_OP_MULT  = 2'b00;
  localparam logic [1:0] MDU_OP_MULTU = 2'b01;
  localparam logic [1:0] MDU_OP_MTHI  = 2'b10;
  localparam logic [1:0] MDU_OP_MTLO  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_FIX   = 2'd3;

  // MULT/MULTU use the multiplier; MTHI/MTLO are direct register writes.
  function automatic logic is_mul_op(input logic [1:0] op);
    return ~op[1];
  endfunction

endpackage

// File: rtl/mul_ufix.sv
// Converts a signed 32x32 product into the unsigned one when is_u_i is set:
// each operand with its MSB set contributes the other operand shifted up by 32.
module mul_ufix (
  input  logic [63:0] prod_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        is_u_i,
  output logic [63:0] p_o
);

  logic [63:0] corr;

  assign corr = (a_i[31] ? {b_i, 32'b0} : 64'b0) + (b_i[31] ? {a_i, 32'b0} : 64'b0);
  assign p_o  = prod_i + (is_u_i ? corr : 64'b0);

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Multiply issue/writeback stage: sequences the external mul32 through restart/wait/fix
// and owns the architectural HI/LO registers.
module mul_hilo_ctrl
  import mul_hilo_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT  = 40,
  parameter int unsigned DONE_MASK = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        op_ready,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_err,
  output logic        mul_rst,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_c,
  input  logic        mul_done
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [1:0]    state_q, state_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic          is_u_q, is_u_d;
  logic          err_q, err_d;
  logic          mul_rst_q, mul_rst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   fix_p;
  logic          accept;

  mul_ufix u_ufix (
    .prod_i (mul_c),
    .a_i    (a_q),
    .b_i    (b_q),
    .is_u_i (is_u_q),
    .p_o    (fix_p)
  );

  assign accept = op_valid && (state_q == ST_IDLE) && !flush;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    is_u_d  = is_u_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul_op(op_code)) begin
            a_d     = rs_data;
            b_d     = rt_data;
            is_u_d  = op_code[0];
            state_d = ST_START;
          end else if (op_code == MDU_OP_MTHI) begin
            hi_d = rs_data;
          end else begin
            lo_d = rs_data;
          end
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Done is a level that may still be high from the previous product right after restart.
        if (mul_done && (cnt_q >= CW'(DONE_MASK))) begin
          state_d = ST_FIX;
        end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        {hi_d, lo_d} = fix_p;
        state_d      = ST_IDLE;
      end
    endcase

    if (flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      err_d   = err_q;
    end

    // mul_rst is mul32's async reset, so it comes straight from a flop: low only while in START.
    mul_rst_d = (state_d != ST_START);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      is_u_q    <= 1'b0;
      err_q     <= 1'b0;
      mul_rst_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      a_q       <= a_d;
      b_q       <= b_d;
      is_u_q    <= is_u_d;
      err_q     <= err_d;
      mul_rst_q <= mul_rst_d;
      cnt_q     <= cnt_d;
    end
  end

  assign op_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign mul_err  = err_q;
  assign mul_rst  = mul_rst_q;
  assign mul_a    = a_q;
  assign mul_b    = b_q;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Bench for mul_hilo_ctrl with a behavioural mul32 stand-in (signed product, settable latency,
// stale-done and stuck-done modes); results are checked through an expected-value queue.
module tb_mul_hilo_ctrl;
  import mul_hilo_ctrl_pkg::*;

  localparam int MAX_WAIT  = 40;
  localparam int DONE_MASK = 2;
  localparam int LAT       = 34;
  localparam int NV        = 13;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        flush = 1'b0;
  logic        op_ready, busy, mul_err, mul_rst, mul_done;
  logic [31:0] hi, lo, mul_a, mul_b;
  logic [63:0] mul_c;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cur;

  int stub_cnt;
  int stub_lat = LAT;
  bit stub_stuck = 1'b0;
  bit stub_stale = 1'b0;
  logic signed [63:0] stub_prod;

  always #5 clk = ~clk;

  mul_hilo_ctrl #(.MAX_WAIT(MAX_WAIT), .DONE_MASK(DONE_MASK)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_code  (op_code),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .flush    (flush),
    .op_ready (op_ready),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .mul_err  (mul_err),
    .mul_rst  (mul_rst),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_c    (mul_c),
    .mul_done (mul_done)
  );

  // mul32 stand-in: counts cycles since restart, product valid once the count reaches stub_lat.
  always @(posedge clk or negedge mul_rst) begin
    if (!mul_rst) stub_cnt <= 0;
    else          stub_cnt <= stub_cnt + 1;
  end

  assign stub_prod = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
  assign mul_c     = (stub_cnt >= stub_lat) ? stub_prod : 64'hDEAD_BEEF_0BAD_F00D;
  assign mul_done  = !stub_stuck && mul_rst &&
                     ((stub_cnt >= stub_lat) || (stub_stale && (stub_cnt < DONE_MASK)));

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[NV];

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub;
    logic signed [63:0] sa, sb;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    if (op == MDU_OP_MULTU) return ua * ub;
    return sa * sb;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    for (int k = 0; k < 100 && !op_ready; k++) @(negedge clk);
    if (!op_ready) check("issue_ready", 64'(op_ready), 64'd1);
    op_valid = 1'b1;
    op_code  = op;
    rs_data  = a;
    rt_data  = b;
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  task automatic run_mul(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    int rst_low;
    bit stable;
    logic [63:0] want;
    issue(op, a, b);
    exp_q.push_back(exp);
    lat = -1;
    rst_low = 0;
    stable = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) begin
        lat = k;
        break;
      end
      if (!mul_rst) rst_low++;
      if (mul_a !== a || mul_b !== b) stable = 1'b0;
    end
    want = exp_q.pop_front();
    check({name, "_hilo"}, {hi, lo}, want);
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_rstpulse"}, 64'(rst_low), 64'd1);
    check({name, "_opstable"}, 64'(stable), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int err_k, done_k;
    bit blocked;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] rexp;

    vecs[0]  = '{MDU_OP_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h00000000};
    vecs[1]  = '{MDU_OP_MTLO,  32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0};
    vecs[2]  = '{MDU_OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3]  = '{MDU_OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vecs[4]  = '{MDU_OP_MULTU, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[5]  = '{MDU_OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[6]  = '{MDU_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[7]  = '{MDU_OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[8]  = '{MDU_OP_MULT,  32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    vecs[9]  = '{MDU_OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[10] = '{MDU_OP_MULT,  32'h00000007, 32'h00000009, 32'h00000000, 32'h0000003F};
    vecs[11] = '{MDU_OP_MULTU, 32'h7FFFFFFF, 32'h80000001, 32'h3FFFFFFF, 32'hFFFFFFFF};
    vecs[12] = '{MDU_OP_MULT,  32'h7FFFFFFF, 32'h80000001, 32'hC0000000, 32'hFFFFFFFF};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_err", 64'(mul_err), 64'd0);
    check("rst_mulrst", 64'(mul_rst), 64'd0);
    check("rst_mulab", {mul_a, mul_b}, 64'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", {62'h0, op_ready, busy}, 64'h2);
    cur = 64'h0;

    // Table of directed vectors
    for (int i = 0; i < NV; i++) begin
      if (!is_mul_op(vecs[i].op)) begin
        issue(vecs[i].op, vecs[i].a, vecs[i].b);
        @(negedge clk);
        check($sformatf("vec%0d_hilo", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
        check($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
      end else begin
        run_mul($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                {vecs[i].hi, vecs[i].lo}, LAT + 3);
      end
      cur = {vecs[i].hi, vecs[i].lo};
    end

    // Random multiplies against the reference model
    for (int i = 0; i < 6; i++) begin
      rop  = $urandom_range(0, 1) == 0 ? MDU_OP_MULT : MDU_OP_MULTU;
      ra   = $urandom();
      rb   = $urandom();
      rexp = model(rop, ra, rb);
      run_mul($sformatf("rnd%0d", i), rop, ra, rb, rexp, LAT + 3);
      cur = rexp;
    end

    // MTLO presented while busy: held off until IDLE, then applied
    issue(MDU_OP_MULT, 32'd7, 32'd9);
    exp_q.push_back(64'h3F);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = MDU_OP_MTLO;
    rs_data  = 32'hCAFEF00D;
    rt_data  = 32'h0;
    done_k   = -1;
    blocked  = 1'b1;
    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      if (!busy) begin
        done_k = k;
        break;
      end
      if (op_ready || lo !== cur[31:0]) blocked = 1'b0;
    end
    check("mtlo_blocked", 64'(blocked), 64'd1);
    check("busy_mul_hilo", {hi, lo}, exp_q.pop_front());
    check("busy_mul_lat", 64'(done_k), 64'(LAT + 3));
    @(negedge clk);
    op_valid = 1'b0;
    check("mtlo_late", {hi, lo}, {32'h0, 32'hCAFEF00D});
    cur = {32'h0, 32'hCAFEF00D};

    // Flush in WAIT cycle 10
    issue(MDU_OP_MULT, 32'd7, 32'd9);
    repeat (12) @(negedge clk);
    check("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_idle", {62'h0, op_ready, busy}, 64'h2);
    check("flush_hilo", {hi, lo}, cur);
    repeat (40) @(negedge clk);
    check("flush_nowrite", {hi, lo}, cur);
    run_mul("mult_3xm1", MDU_OP_MULT, 32'd3, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFD, LAT + 3);
    cur = 64'hFFFFFFFF_FFFFFFFD;

    // Flush in IDLE blocks a same-cycle op
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = MDU_OP_MTHI;
    rs_data  = 32'h55555555;
    flush    = 1'b1;
    @(posedge clk);
    #1 begin op_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    check("idle_flush_block", {hi, lo}, cur);

    // Stale done during the mask window carries a garbage product
    stub_stale = 1'b1;
    stub_lat   = DONE_MASK;
    run_mul("done_mask", MDU_OP_MULT, 32'h1234, 32'h10, 64'h12340, DONE_MASK + 3);
    cur = 64'h12340;
    stub_stale = 1'b0;
    stub_lat   = LAT;

    // Multiplier never completes: timeout raises sticky mul_err
    stub_stuck = 1'b1;
    issue(MDU_OP_MULT, 32'd2, 32'd3);
    err_k = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mul_err) begin
        err_k = k;
        break;
      end
    end
    check("timeout_lat", 64'(err_k), 64'(MAX_WAIT + 1));
    check("timeout_idle", 64'(busy), 64'd0);
    check("timeout_hilo", {hi, lo}, cur);
    stub_stuck = 1'b0;
    run_mul("after_err", MDU_OP_MULTU, 32'd2, 32'd3, 64'd6, LAT + 3);
    check("err_sticky", 64'(mul_err), 64'd1);
    cur = 64'd6;

    // Reset in the middle of WAIT
    issue(MDU_OP_MULT, 32'h0000FFFF, 32'h0000FFFF);
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_hilo", {hi, lo}, 64'h0);
    check("midrst_err_mulrst", {62'h0, mul_err, mul_rst}, 64'h0);
    check("midrst_mulab", {mul_a, mul_b}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_release", {62'h0, op_ready, busy}, 64'h2);
    repeat (45) @(negedge clk);
    check("midrst_nowrite", {hi, lo}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
